// File: rtl/core_run_controller.sv
`default_nettype none
//============================================================================
// Module      : core_run_controller
// Description : Run controller for the MIPS core. A start request holds the
//               core in reset for RESET_CYCLES cycles, then enables the core
//               for a programmed number of cycles. The run ends early if the
//               core raises halt. In DONE the core is left frozen so that its
//               architectural state can be inspected.
//
// Parameters  : CNT_W        - width of run_cycles / cycle_count
//               RESET_CYCLES - cycles core_reset is held in RESET (1..255)
//
// Ports       : clk          - system clock, rising edge
//               reset        - synchronous active-high controller reset
//               start        - launch request (accepted in IDLE or DONE)
//               run_cycles   - core cycles to execute, latched on start
//               halt         - core halt indication, honoured only in RUN
//               step_mode    - (optional) single-step enable
//               step         - (optional) one enabled core cycle per pulse
//               core_reset   - reset to the core (IDLE, RESET)
//               core_en      - clock-enable to the core (RUN)
//               busy         - high in RESET and RUN
//               done         - high in DONE
//               halted       - high in DONE when the run ended on halt
//               cycle_count  - enabled core cycles in current / last run
//
// Optional    : define CORE_RUN_STEP_MODE_EN to add step_mode / step ports.
//
// Revision    : 1.0 - initial release
//============================================================================
module core_run_controller #(
    parameter int CNT_W        = 16,
    parameter int RESET_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             halt,
`ifdef CORE_RUN_STEP_MODE_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic             core_reset,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_reset = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [7:0] c_rst_load = 8'(RESET_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [7:0]       r_rst_cnt;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_count;
    logic             r_halted;

    logic             w_launch;
    logic             w_run_en;
    logic [CNT_W-1:0] w_count_inc;

    // Launch is accepted only from the idle-like states; start while busy
    // is dropped.
    assign w_launch    = start & ((r_state == c_st_idle) | (r_state == c_st_done));
    assign w_count_inc = r_count + 1'b1;

`ifdef CORE_RUN_STEP_MODE_EN
    assign w_run_en = (r_state == c_st_run) & (~step_mode | step);
`else
    assign w_run_en = (r_state == c_st_run);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_next_state = c_st_reset;
                end
            end
            c_st_reset: begin
                if (r_rst_cnt == 8'd0) begin
                    w_next_state = (r_target == '0) ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                // The target check compares the post-increment count so that
                // cycle_count stops exactly at target and can never wrap.
                if (w_run_en && (halt || (w_count_inc == r_target))) begin
                    w_next_state = c_st_done;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // Run datapath: reset counter, target, cycle counter, halt flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rst_cnt <= 8'd0;
            r_target  <= '0;
            r_count   <= '0;
            r_halted  <= 1'b0;
        end else if (w_launch) begin
            r_rst_cnt <= c_rst_load;
            r_target  <= run_cycles;
            r_count   <= '0;
            r_halted  <= 1'b0;
        end else if (r_state == c_st_reset) begin
            if (r_rst_cnt != 8'd0) begin
                r_rst_cnt <= r_rst_cnt - 8'd1;
            end
        end else if (w_run_en) begin
            r_count <= w_count_inc;
            if (halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Output decode
    always_comb begin
        core_reset  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        core_en     = w_run_en;
        halted      = r_halted & (r_state == c_st_done);
        cycle_count = r_count;
        case (r_state)
            c_st_idle:  core_reset = 1'b1;
            c_st_reset: begin
                core_reset = 1'b1;
                busy       = 1'b1;
            end
            c_st_run:   busy = 1'b1;
            c_st_done:  done = 1'b1;
            default:    core_reset = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_core_run_controller.sv
`default_nettype none
//============================================================================
// Module      : tb_core_run_controller
// Description : Self-checking bench for core_run_controller. A vector table
//               covers cycle-by-cycle behaviour for short runs; hand-written
//               sequences cover the long run, halt, restart, mid-run reset,
//               longer reset pulse and (optionally) single-step mode.
// Revision    : 1.0 - initial release
//============================================================================
module tb_core_run_controller;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             start4;
    logic [CNT_W-1:0] run_cycles;
    logic             halt;
    logic             step_mode;
    logic             step;

    logic             core_reset, core_en, busy, done, halted;
    logic [CNT_W-1:0] cycle_count;
    logic             core_reset4, core_en4, busy4, done4, halted4;
    logic [CNT_W-1:0] cycle_count4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_run_controller #(.CNT_W(CNT_W), .RESET_CYCLES(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .run_cycles  (run_cycles),
        .halt        (halt),
`ifdef CORE_RUN_STEP_MODE_EN
        .step_mode   (step_mode),
        .step        (step),
`endif
        .core_reset  (core_reset),
        .core_en     (core_en),
        .busy        (busy),
        .done        (done),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    core_run_controller #(.CNT_W(CNT_W), .RESET_CYCLES(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .start       (start4),
        .run_cycles  (run_cycles),
        .halt        (halt),
`ifdef CORE_RUN_STEP_MODE_EN
        .step_mode   (step_mode),
        .step        (step),
`endif
        .core_reset  (core_reset4),
        .core_en     (core_en4),
        .busy        (busy4),
        .done        (done4),
        .halted      (halted4),
        .cycle_count (cycle_count4)
    );

    typedef struct {
        logic             rst;
        logic             st;
        logic [CNT_W-1:0] rc;
        logic             hlt;
        logic             e_cr;
        logic             e_en;
        logic             e_busy;
        logic             e_done;
        logic             e_halted;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic st, input int rc, input logic hlt,
                                input logic cr, input logic en, input logic bsy,
                                input logic dn, input logic hd, input int cnt);
        vec_t v;
        v.rst = rst; v.st = st; v.rc = CNT_W'(rc); v.hlt = hlt;
        v.e_cr = cr; v.e_en = en; v.e_busy = bsy; v.e_done = dn;
        v.e_halted = hd; v.e_cnt = CNT_W'(cnt);
        return v;
    endfunction

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; start4 = 1'b0; run_cycles = '0;
        halt = 1'b0; step_mode = 1'b0; step = 1'b0;

        // Inputs applied before an edge, expected outputs just after it.
        //             rst st  rc hlt  cr en bsy dn hd cnt
        vecs[0]  = mk(1, 0,  0, 0,   1, 0, 0,  0, 0, 0); // reset -> IDLE
        vecs[1]  = mk(0, 1,  0, 0,   1, 0, 1,  0, 0, 0); // accept rc=0
        vecs[2]  = mk(0, 0,  0, 0,   0, 0, 0,  1, 0, 0); // zero run -> DONE
        vecs[3]  = mk(0, 0,  0, 1,   0, 0, 0,  1, 0, 0); // halt in DONE ignored
        vecs[4]  = mk(0, 1,  2, 0,   1, 0, 1,  0, 0, 0); // relaunch rc=2
        vecs[5]  = mk(0, 1,  9, 0,   0, 1, 1,  0, 0, 0); // start while busy
        vecs[6]  = mk(0, 1,  9, 0,   0, 1, 1,  0, 0, 1);
        vecs[7]  = mk(0, 0,  0, 0,   0, 0, 0,  1, 0, 2); // count reached
        vecs[8]  = mk(0, 0,  0, 1,   0, 0, 0,  1, 0, 2); // halt in DONE ignored
        vecs[9]  = mk(0, 1,  1, 0,   1, 0, 1,  0, 0, 0); // relaunch rc=1
        vecs[10] = mk(0, 0,  0, 0,   0, 1, 1,  0, 0, 0);
        vecs[11] = mk(0, 0,  0, 1,   0, 0, 0,  1, 1, 1); // halt + count coincide
        vecs[12] = mk(0, 1,  3, 0,   1, 0, 1,  0, 0, 0); // relaunch clears halted
        vecs[13] = mk(0, 0,  0, 0,   0, 1, 1,  0, 0, 0);
        vecs[14] = mk(0, 0,  0, 0,   0, 1, 1,  0, 0, 1);
        vecs[15] = mk(0, 0,  0, 1,   0, 0, 0,  1, 1, 2); // early halt
        vecs[16] = mk(1, 0,  0, 0,   1, 0, 0,  0, 0, 0); // reset from DONE

        tick();
        for (int i = 0; i < 17; i++) begin
            reset = vecs[i].rst; start = vecs[i].st;
            run_cycles = vecs[i].rc; halt = vecs[i].hlt;
            tick();
            chk($sformatf("v%0d core_reset", i), 32'(core_reset), 32'(vecs[i].e_cr));
            chk($sformatf("v%0d core_en", i),    32'(core_en),    32'(vecs[i].e_en));
            chk($sformatf("v%0d busy", i),       32'(busy),       32'(vecs[i].e_busy));
            chk($sformatf("v%0d done", i),       32'(done),       32'(vecs[i].e_done));
            chk($sformatf("v%0d halted", i),     32'(halted),     32'(vecs[i].e_halted));
            chk($sformatf("v%0d cycle_count", i), 32'(cycle_count), 32'(vecs[i].e_cnt));
        end
        reset = 1'b0; start = 1'b0; halt = 1'b0;
        tick();

        // 16-cycle run: one reset cycle, then exactly 16 enabled cycles
        run_cycles = 16; start = 1'b1; tick(); start = 1'b0;
        n = 0;
        for (int g = 0; g < 50 && core_reset; g++) begin n++; tick(); end
        chk("run16 reset_len", 32'(n), 32'd1);
        n = 0;
        for (int g = 0; g < 50 && core_en; g++) begin n++; tick(); end
        chk("run16 en_len", 32'(n), 32'd16);
        chk("run16 done", 32'(done), 32'd1);
        chk("run16 count", 32'(cycle_count), 32'd16);
        chk("run16 halted", 32'(halted), 32'd0);
        chk("run16 core_reset", 32'(core_reset), 32'd0);

        // Halt on the 5th RUN cycle of a 100-cycle run
        run_cycles = 100; start = 1'b1; tick(); start = 1'b0;
        tick();
        repeat (4) tick();
        chk("halt5 en", 32'(core_en), 32'd1);
        chk("halt5 pre_count", 32'(cycle_count), 32'd4);
        halt = 1'b1; tick(); halt = 1'b0;
        chk("halt5 done", 32'(done), 32'd1);
        chk("halt5 count", 32'(cycle_count), 32'd5);
        chk("halt5 halted", 32'(halted), 32'd1);
        halt = 1'b1; tick(); halt = 1'b0;
        chk("halt5 hold count", 32'(cycle_count), 32'd5);
        chk("halt5 hold halted", 32'(halted), 32'd1);

        // Relaunch from DONE with start held high through the run
        run_cycles = 3; start = 1'b1; tick();
        chk("rerun restart count", 32'(cycle_count), 32'd0);
        run_cycles = 7;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rerun count%0d", k), 32'(cycle_count), 32'(k));
            chk($sformatf("rerun en%0d", k), 32'(core_en), 32'd1);
            if (k == 2) start = 1'b0;
            tick();
        end
        chk("rerun done", 32'(done), 32'd1);
        chk("rerun count", 32'(cycle_count), 32'd3);

        // Reset on RUN cycle 7 aborts the run
        run_cycles = 100; start = 1'b1; tick(); start = 1'b0;
        tick();
        repeat (6) tick();
        chk("abort pre_count", 32'(cycle_count), 32'd6);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort core_reset", 32'(core_reset), 32'd1);
        chk("abort core_en", 32'(core_en), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort count", 32'(cycle_count), 32'd0);
        tick();
        chk("abort stays idle", 32'(done), 32'd0);

        // Four-cycle reset pulse before the first enabled cycle
        run_cycles = 2; start4 = 1'b1; tick(); start4 = 1'b0;
        n = 0;
        for (int g = 0; g < 50 && core_reset4 && !core_en4; g++) begin n++; tick(); end
        chk("rst4 reset_len", 32'(n), 32'd4);
        n = 0;
        for (int g = 0; g < 50 && core_en4; g++) begin n++; tick(); end
        chk("rst4 en_len", 32'(n), 32'd2);
        chk("rst4 done", 32'(done4), 32'd1);
        chk("rst4 count", 32'(cycle_count4), 32'd2);

`ifdef CORE_RUN_STEP_MODE_EN
        // Single-step: core_en only on step cycles, DONE after third step
        step_mode = 1'b1; run_cycles = 3; start = 1'b1; tick(); start = 1'b0;
        tick();
        n = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            step = (k % 4 == 3);
            #1;
            chk($sformatf("step en k%0d", k), 32'(core_en), 32'(step));
            if (core_en) n++;
            tick();
        end
        step = 1'b0;
        chk("step steps", 32'(n), 32'd3);
        chk("step done", 32'(done), 32'd1);
        chk("step count", 32'(cycle_count), 32'd3);
        step_mode = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
